// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - DW_DEFAULT / AW_DEFAULT : default operand and register-address widths
//   - op_t                    : operation encoding carried on the op port
//   - state_t                 : FSM state type, also exposed on fsm_state
//   - DIV_EN                  : 1 when the build defines MULDIV_DIV_EN
// Optional feature macro: MULDIV_DIV_EN (division datapath).
package muldiv_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int AW_DEFAULT = 3;

  typedef enum logic [1:0] {
    OP_MUL_LO = 2'b00,
    OP_MUL_HI = 2'b01,
    OP_DIV_Q  = 2'b10,
    OP_DIV_R  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative datapath.
//   The working register is the pair {hi, lo}.
//   MUL: lo starts as the multiplier, hi as zero. Each step conditionally
//        adds b into hi and shifts {carry, hi, lo} right by one; after DW
//        steps {hi, lo} holds the full 2*DW product.
//   DIV: lo starts as the dividend, hi (partial remainder) as zero. Each
//        step shifts {hi, lo} left, tries hi - b and keeps it if it does not
//        underflow, shifting the quotient bit into lo. After DW steps
//        lo = quotient, hi = remainder. With b = 0 every trial succeeds,
//        giving quotient all-ones and remainder = dividend.
// Ports:
//   is_div  (in, only with MULDIV_DIV_EN) : select divide step
//   hi, lo  (in,  DW)                     : current working register
//   b       (in,  DW)                     : multiplicand / divisor
//   hi_next, lo_next (out, DW)            : working register after the step
// Optional feature macro: MULDIV_DIV_EN.
module muldiv_step #(
  parameter int DW = 16
) (
`ifdef MULDIV_DIV_EN
  input  logic          is_div,
`endif
  input  logic [DW-1:0] hi,
  input  logic [DW-1:0] lo,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] hi_next,
  output logic [DW-1:0] lo_next
);

  logic [DW:0] sum;
`ifdef MULDIV_DIV_EN
  logic [DW:0] shifted;
  logic [DW:0] diff;
`endif

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    hi_next = sum[DW:1];
    lo_next = {sum[0], lo[DW-1:1]};
`ifdef MULDIV_DIV_EN
    shifted = {hi, lo[DW-1]};
    diff    = shifted - {1'b0, b};
    if (is_div) begin
      // Explicit compare rather than a borrow bit: with b = 0 the shifted
      // value can exceed DW bits and must still count as "fits".
      if (shifted >= {1'b0, b}) begin
        hi_next = diff[DW-1:0];
        lo_next = {lo[DW-2:0], 1'b1};
      end else begin
        hi_next = shifted[DW-1:0];
        lo_next = {lo[DW-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit writing its result
// into a register file.
// Handshake: start is a request sampled only on a rising edge in IDLE;
//   busy=1 means a request would be ignored. An accepted request completes
//   with a one-cycle done pulse; for writing ops wr_en/wr_addr/wr_data are
//   valid in that same cycle, and err is valid only while done=1.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, op[1:0]        : request and operation (see muldiv_pkg::op_t)
//   a, b (DW)             : operands from register-file read ports
//   dst (AW)              : destination register address
//   busy, done, err       : status
//   wr_en, wr_addr, wr_data : register-file write port
//   fsm_state             : current FSM state (debug)
// Optional feature macro: MULDIV_DIV_EN (division datapath). Without it,
//   ops 10/11 complete immediately with done=1, err=1 and no write.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [AW-1:0] dst,
  output logic          busy,
  output logic          done,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          err,
  output state_t        fsm_state
);

  localparam int CW = $clog2(DW);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] hi, lo, b_q;
  logic [DW-1:0] hi_next, lo_next;
  op_t           op_q;
  logic [AW-1:0] dst_q;

  muldiv_step #(.DW(DW)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div  (op_q[1]),
`endif
    .hi      (hi),
    .lo      (lo),
    .b       (b_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      b_q     <= '0;
      op_q    <= OP_MUL_LO;
      dst_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      // Status pulses default low; only the transition into DONE raises them.
      done  <= 1'b0;
      wr_en <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            b_q   <= b;
            op_q  <= op_t'(op);
            dst_q <= dst;
            cnt   <= '0;
            hi    <= '0;
            lo    <= a;
            busy  <= 1'b1;
            if (op[1] && !DIV_EN) begin
              // Division not built in: report unsupported, write nothing.
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          hi  <= hi_next;
          lo  <= lo_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            cnt     <= '0;
            state   <= ST_DONE;
            done    <= 1'b1;
            wr_en   <= 1'b1;
            wr_addr <= dst_q;
            // MUL high and DIV remainder live in hi; MUL low and quotient in lo.
            wr_data <= op_q[0] ? hi_next : lo_next;
            err     <= DIV_EN && op_q[1] && (b_q == '0);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit (DW=16, AW=3).
// Latency is counted in edges from the capture edge (capture edge = 1), so
// a 16-cycle RUN shows done/wr_en at count 17.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] a, b;
  logic [AW-1:0] dst;
  logic          busy, done, wr_en, err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  state_t        fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;

  muldiv_unit #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .dst       (dst),
    .busy      (busy),
    .done      (done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count write strobes, sampled mid-cycle
  always @(negedge clk) if (wr_en) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one request and wait (bounded) for done. With pester set, start is
  // re-pulsed with different operands twice during RUN and once in DONE.
  task automatic run_op(input logic [1:0] o, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                        input logic [AW-1:0] d, input bit pester,
                        output logic [DW-1:0] data, output logic e, output logic we,
                        output logic [AW-1:0] addr, output int lat);
    @(negedge clk);
    op = o; a = av; b = bv; dst = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 8) begin
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_no_wr", 32'({done, wr_en, err}), 32'd0);
      end
      if (pester && (lat == 4 || lat == 15)) begin
        start = 1'b1; a = ~av; b = bv + 1'b1; dst = ~d; op = ~o;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    data = wr_data; e = err; we = wr_en; addr = wr_addr;
    check("done_busy", 32'(busy), 32'd1);
    if (pester) start = 1'b1;   // sampled by the DONE->IDLE edge
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after", 32'({busy, done, wr_en, err}), 32'd0);
  endtask

  task automatic mul_case(input string tag, input logic [1:0] o, input logic [DW-1:0] av,
                          input logic [DW-1:0] bv, input logic [AW-1:0] d, input bit pester,
                          input logic [DW-1:0] exp_data, input logic exp_err);
    logic [DW-1:0] data;
    logic e, we;
    logic [AW-1:0] addr;
    int lat, w0;
    w0 = wr_cnt;
    run_op(o, av, bv, d, pester, data, e, we, addr, lat);
    check({tag, "_lat"}, 32'(lat), 32'd17);
    check({tag, "_data"}, 32'(data), 32'(exp_data));
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    check({tag, "_we"}, 32'(we), 32'd1);
    check({tag, "_addr"}, 32'(addr), 32'(d));
    repeat (3) @(posedge clk);
    #1 check({tag, "_nwrites"}, 32'(wr_cnt - w0), 32'd1);
  endtask

`ifndef MULDIV_DIV_EN
  task automatic div_off_case(input string tag, input logic [1:0] o, input logic [DW-1:0] av,
                              input logic [DW-1:0] bv);
    logic [DW-1:0] data;
    logic e, we;
    logic [AW-1:0] addr;
    int lat, w0;
    w0 = wr_cnt;
    run_op(o, av, bv, 3'd5, 1'b0, data, e, we, addr, lat);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_err"}, 32'(e), 32'd1);
    check({tag, "_we"}, 32'(we), 32'd0);
    repeat (3) @(posedge clk);
    #1 check({tag, "_nwrites"}, 32'(wr_cnt - w0), 32'd0);
  endtask
`endif

  initial begin
    int w0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; dst = '0;
    #12;
    check("rst_status", 32'({busy, done, wr_en, err}), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // multiply
    mul_case("mul_lo_3x5",    2'b00, 16'h0003, 16'h0005, 3'd2, 1'b0, 16'h000F, 1'b0);
    mul_case("mul_hi_ffff",   2'b01, 16'hFFFF, 16'hFFFF, 3'd1, 1'b0, 16'hFFFE, 1'b0);
    mul_case("mul_lo_ffff",   2'b00, 16'hFFFF, 16'hFFFF, 3'd7, 1'b0, 16'h0001, 1'b0);
    mul_case("mul_lo_1234",   2'b00, 16'h1234, 16'h0010, 3'd3, 1'b0, 16'h2340, 1'b0);
    mul_case("mul_hi_1234",   2'b01, 16'h1234, 16'h0010, 3'd4, 1'b0, 16'h0001, 1'b0);

    // divide
`ifdef MULDIV_DIV_EN
    mul_case("div_q_100_7",   2'b10, 16'h0064, 16'h0007, 3'd6, 1'b0, 16'h000E, 1'b0);
    mul_case("div_r_100_7",   2'b11, 16'h0064, 16'h0007, 3'd6, 1'b0, 16'h0002, 1'b0);
    mul_case("div_q_by0",     2'b10, 16'h1234, 16'h0000, 3'd0, 1'b0, 16'hFFFF, 1'b1);
    mul_case("div_r_by0",     2'b11, 16'h1234, 16'h0000, 3'd0, 1'b0, 16'h1234, 1'b1);
    mul_case("div_q_ffff_10", 2'b10, 16'hFFFF, 16'h0010, 3'd1, 1'b0, 16'h0FFF, 1'b0);
`else
    div_off_case("div_q_off", 2'b10, 16'h0064, 16'h0007);
    div_off_case("div_r_off", 2'b11, 16'h1234, 16'h0000);
`endif
    // MUL still fine after the divide requests
    mul_case("mul_lo_7x9",    2'b00, 16'h0007, 16'h0009, 3'd5, 1'b0, 16'h003F, 1'b0);

    // start re-pulsed during RUN and DONE with other operands: ignored
    mul_case("pester",        2'b00, 16'h0003, 16'h0005, 3'd2, 1'b1, 16'h000F, 1'b0);
    mul_case("after_pester",  2'b01, 16'h8000, 16'h0004, 3'd6, 1'b0, 16'h0002, 1'b0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    op = 2'b00; a = 16'h0003; b = 16'h0005; dst = 3'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_mid_wr", 32'({done, wr_en, err}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_write", 32'(wr_cnt - w0), 32'd0);
    check("rst_idle", 32'(fsm_state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
